// File: rtl/pupil_centroid_if.sv
// Pixel-stream inputs and centroid result outputs of pupil_centroid, bundled as one interface.
// The master modport drives the pixel stream; the slave modport is the centroid block.
interface pupil_centroid_if #(
    parameter int unsigned CW    = 13,
    parameter int unsigned CNT_W = 21
) ();
    logic             iFVAL;
    logic             iDVAL;
    logic [9:0]       iDATA;
    logic [CW-1:0]    iH_Cont;
    logic [CW-1:0]    iV_Cont;
    logic [9:0]       iThreshold;
    logic [CW-1:0]    oCenter_X;
    logic [CW-1:0]    oCenter_Y;
    logic [CNT_W-1:0] oPixCount;
    logic             oFound;
    logic             oValid;
    logic             oBusy;
    logic             oOverrun;

    modport master (
        output iFVAL, iDVAL, iDATA, iH_Cont, iV_Cont, iThreshold,
        input  oCenter_X, oCenter_Y, oPixCount, oFound, oValid, oBusy, oOverrun
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA, iH_Cont, iV_Cont, iThreshold,
        output oCenter_X, oCenter_Y, oPixCount, oFound, oValid, oBusy, oOverrun
    );
endinterface

// File: rtl/pupil_centroid.sv
// Dark-pupil centroid: per-frame dark-pixel count and X/Y sums, then a serial restoring divide.
// Optional search window restricting dark pixels is enabled by defining PUPIL_ROI_EN.
module pupil_centroid #(
    parameter int unsigned CW      = 13,
    parameter int unsigned CNT_W   = 21,
    parameter int unsigned SUM_W   = 34,
    parameter int unsigned MIN_PIX = 16,
    parameter int unsigned ROI_X0  = 256,
    parameter int unsigned ROI_X1  = 1279,
    parameter int unsigned ROI_Y0  = 0,
    parameter int unsigned ROI_Y1  = 959
) (
    input logic             iCLK,
    input logic             iRST,
    pupil_centroid_if.slave bus
);
    localparam int unsigned BW = $clog2(SUM_W);

    typedef enum logic [1:0] {StIdle, StDivX, StDivY, StDone} state_e;

    state_e           state_q, state_d;
    logic             fval_q;
    logic [9:0]       thr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W-1:0] sumx_q, sumy_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] rem_q;
    logic [SUM_W-1:0] dvd_q;
    logic [SUM_W-1:0] sumy_snap_q;
    logic [BW-1:0]    bit_q;
    logic             found_n_q;
    logic [CW-1:0]    qx_q;
    logic [CW-1:0]    cx_q, cy_q;
    logic [CNT_W-1:0] pix_q;
    logic             found_q, valid_q, overrun_q;

    logic             frame_start, frame_end, in_roi, dark, snap, enough, last;
    logic             busy, do_step, done;
    logic [CNT_W:0]   rem_sh;
    logic             ge;
    logic [CNT_W-1:0] rem_nx;
    logic [SUM_W-1:0] quo_nx;

    assign frame_start = ~fval_q & bus.iFVAL;
    assign frame_end   = fval_q & ~bus.iFVAL;

`ifdef PUPIL_ROI_EN
    assign in_roi = (bus.iH_Cont >= CW'(ROI_X0)) && (bus.iH_Cont <= CW'(ROI_X1)) &&
                    (bus.iV_Cont >= CW'(ROI_Y0)) && (bus.iV_Cont <= CW'(ROI_Y1));
`else
    assign in_roi = 1'b1;
`endif

    assign dark   = bus.iFVAL & bus.iDVAL & (bus.iDATA <= thr_q) & in_roi;
    assign snap   = frame_end & (state_q == StIdle);
    assign enough = cnt_q >= CNT_W'(MIN_PIX);
    assign last   = bit_q == BW'(SUM_W - 1);

    // Restoring divide step: dividend MSB shifts into the remainder, quotient bit into the LSB.
    assign rem_sh = {rem_q, dvd_q[SUM_W-1]};
    assign ge     = rem_sh >= {1'b0, div_q};
    assign rem_nx = ge ? CNT_W'(rem_sh - {1'b0, div_q}) : rem_sh[CNT_W-1:0];
    assign quo_nx = {dvd_q[SUM_W-2:0], ge};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_q <= 1'b0;
            thr_q  <= '0;
            cnt_q  <= '0;
            sumx_q <= '0;
            sumy_q <= '0;
        end else begin
            fval_q <= bus.iFVAL;
            if (frame_start) begin
                thr_q  <= bus.iThreshold;
                cnt_q  <= dark ? CNT_W'(1) : '0;
                sumx_q <= dark ? SUM_W'(bus.iH_Cont) : '0;
                sumy_q <= dark ? SUM_W'(bus.iV_Cont) : '0;
            end else if (dark) begin
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                sumx_q <= sumx_q + SUM_W'(bus.iH_Cont);
                sumy_q <= sumy_q + SUM_W'(bus.iV_Cont);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (snap) state_d = enough ? StDivX : StDone;
            StDivX:  if (last) state_d = StDivY;
            StDivY:  if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = 1'b1;
        do_step = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle:         busy    = 1'b0;
            StDivX, StDivY: do_step = 1'b1;
            StDone:         done    = 1'b1;
            default:        busy    = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            div_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            sumy_snap_q <= '0;
            bit_q       <= '0;
            found_n_q   <= 1'b0;
            qx_q        <= '0;
        end else if (snap) begin
            div_q       <= cnt_q;
            rem_q       <= '0;
            dvd_q       <= sumx_q;
            sumy_snap_q <= sumy_q;
            bit_q       <= '0;
            found_n_q   <= enough;
        end else if (do_step) begin
            if (last) begin
                bit_q <= '0;
                rem_q <= '0;
                // X quotient is parked so the same shift register can divide Y next.
                if (state_q == StDivX) begin
                    qx_q  <= quo_nx[CW-1:0];
                    dvd_q <= sumy_snap_q;
                end else begin
                    dvd_q <= quo_nx;
                end
            end else begin
                bit_q <= bit_q + BW'(1);
                rem_q <= rem_nx;
                dvd_q <= quo_nx;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cx_q      <= '0;
            cy_q      <= '0;
            pix_q     <= '0;
            found_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= done;
            overrun_q <= frame_end & busy;
            if (done) begin
                pix_q   <= div_q;
                found_q <= found_n_q;
                if (found_n_q) begin
                    cx_q <= qx_q;
                    cy_q <= dvd_q[CW-1:0];
                end
            end
        end
    end

    assign bus.oCenter_X = cx_q;
    assign bus.oCenter_Y = cy_q;
    assign bus.oPixCount = pix_q;
    assign bus.oFound    = found_q;
    assign bus.oValid    = valid_q;
    assign bus.oBusy     = busy;
    assign bus.oOverrun  = overrun_q;
endmodule
